// File: rtl/dcache_responder.sv
// dcache_responder: word-organised SRAM answering CPU-to-dcache requests after LATENCY wait states,
// with LL/SC support. Define DCACHE_RESP_DIFF_EN to build the difftest trace registers.
module dcache_responder #(
   parameter int ADDR_WIDTH = 10,
   parameter int LATENCY    = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid,
   input  logic        op,
   input  logic [31:0] addr,
   input  logic [3:0]  write_type,
   input  logic [31:0] w_data_CPU,
   input  logic        is_atom,
   input  logic        signed_ext,
   input  logic        llbit_clr,
   output logic        data_valid,
   output logic [31:0] r_data_CPU,
   output logic [6:0]  cache_exception,
   output logic [31:0] cache_badv,
   output logic [31:0] vaddr_diff,
   output logic [31:0] paddr_diff,
   output logic [31:0] data_diff
);
   localparam int         DEPTH    = 1 << ADDR_WIDTH;
   localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

   typedef enum logic [1:0] {S_IDLE = 2'b00, S_WAIT = 2'b01, S_RESP = 2'b10} state_t;

   function automatic logic is_misaligned(input logic [3:0] wt, input logic [1:0] off);
      logic bad;
      case (wt)
         4'b0001: bad = 1'b0;
         4'b0011: bad = off[0];
         default: bad = (off != 2'b00);
      endcase
      return bad;
   endfunction

   function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [3:0] wt,
                                                input logic [1:0] off, input logic sx);
      logic [31:0] sh;
      logic [31:0] res;
      sh = word >> {off, 3'b000};
      case (wt)
         4'b0001: res = {{24{sx & sh[7]}}, sh[7:0]};
         4'b0011: res = {{16{sx & sh[15]}}, sh[15:0]};
         default: res = word;
      endcase
      return res;
   endfunction

   state_t                state_r, state_nxt_s;
   logic [3:0]            cnt_r, cnt_nxt_s;
   logic                  llbit_r, llbit_fsm_s, llbit_nxt_s;
   logic                  op_r, atom_r, sext_r;
   logic [31:0]           addr_r, wdata_r;
   logic [3:0]            wtype_r;
   logic                  latch_s;
   logic                  data_valid_nxt_s;
   logic [31:0]           r_data_nxt_s;
   logic [6:0]            exc_nxt_s;
   logic [31:0]           badv_nxt_s;
   logic [31:0]           mem_r [DEPTH];
   logic [ADDR_WIDTH-1:0] idx_s;
   logic [1:0]            off_s;
   logic [31:0]           rd_word_s, rd_data_s, wdata_sh_s;
   logic [3:0]            be_s;
   logic                  fire_s, wr_en_s;

   assign idx_s      = addr_r[ADDR_WIDTH+1:2];
   assign off_s      = addr_r[1:0];
   assign rd_word_s  = mem_r[idx_s];
   assign rd_data_s  = atom_r ? rd_word_s : load_extend(rd_word_s, wtype_r, off_s, sext_r);
   assign wdata_sh_s = wdata_r << {off_s, 3'b000};
   assign be_s       = atom_r ? 4'b1111 : (wtype_r << off_s);
   assign fire_s     = (state_r == S_WAIT) && (cnt_r == 4'd0);
   // A failed SC (llbit clear) must not touch memory.
   assign wr_en_s    = fire_s && op_r && (!atom_r || llbit_r);

   // Next-state, counter, LL-bit and response values.
   always_comb begin
      state_nxt_s      = state_r;
      cnt_nxt_s        = cnt_r;
      llbit_fsm_s      = llbit_r;
      latch_s          = 1'b0;
      data_valid_nxt_s = 1'b0;
      r_data_nxt_s     = 32'h0;
      exc_nxt_s        = 7'd0;
      badv_nxt_s       = 32'h0;
      case (state_r)
         S_IDLE: begin
            if (valid) begin
               latch_s = 1'b1;
               if (is_misaligned(write_type, addr[1:0])) begin
                  state_nxt_s = S_RESP;
                  exc_nxt_s   = 7'd1;
                  badv_nxt_s  = addr;
               end else begin
                  state_nxt_s = S_WAIT;
                  cnt_nxt_s   = LAT_LOAD;
               end
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_WAIT: begin
            if (cnt_r == 4'd0) begin
               state_nxt_s      = S_RESP;
               data_valid_nxt_s = 1'b1;
               if (op_r) begin
                  r_data_nxt_s = atom_r ? {31'd0, llbit_r} : 32'h0;
                  llbit_fsm_s  = atom_r ? 1'b0 : llbit_r;
               end else begin
                  r_data_nxt_s = rd_data_s;
                  llbit_fsm_s  = atom_r ? 1'b1 : llbit_r;
               end
            end else begin
               cnt_nxt_s = cnt_r - 4'd1;
            end
         end
         S_RESP:  state_nxt_s = S_IDLE;
         default: state_nxt_s = S_IDLE;
      endcase
      llbit_nxt_s = llbit_clr ? 1'b0 : llbit_fsm_s;
   end

   // State, request latch and registered response outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r         <= S_IDLE;
         cnt_r           <= 4'd0;
         llbit_r         <= 1'b0;
         op_r            <= 1'b0;
         atom_r          <= 1'b0;
         sext_r          <= 1'b0;
         addr_r          <= 32'h0;
         wdata_r         <= 32'h0;
         wtype_r         <= 4'd0;
         data_valid      <= 1'b0;
         r_data_CPU      <= 32'h0;
         cache_exception <= 7'd0;
         cache_badv      <= 32'h0;
      end else begin
         state_r         <= state_nxt_s;
         cnt_r           <= cnt_nxt_s;
         llbit_r         <= llbit_nxt_s;
         data_valid      <= data_valid_nxt_s;
         r_data_CPU      <= r_data_nxt_s;
         cache_exception <= exc_nxt_s;
         cache_badv      <= badv_nxt_s;
         if (latch_s) begin
            op_r    <= op;
            atom_r  <= is_atom;
            sext_r  <= signed_ext;
            addr_r  <= addr;
            wdata_r <= w_data_CPU;
            wtype_r <= write_type;
         end
      end
   end

   // Byte-lane SRAM write; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (wr_en_s && be_s[b] && !rst) begin
            mem_r[idx_s][8*b +: 8] <= wdata_sh_s[8*b +: 8];
         end
      end
   end

`ifdef DCACHE_RESP_DIFF_EN
   // Difftest trace of the access completing in the coming RESP cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vaddr_diff <= 32'h0;
         paddr_diff <= 32'h0;
         data_diff  <= 32'h0;
      end else if (fire_s) begin
         vaddr_diff <= addr_r;
         paddr_diff <= addr_r;
         data_diff  <= op_r ? wdata_sh_s : rd_data_s;
      end else begin
         vaddr_diff <= 32'h0;
         paddr_diff <= 32'h0;
         data_diff  <= 32'h0;
      end
   end
`else
   logic unused_addr_s;
   assign unused_addr_s = ^addr_r[31:ADDR_WIDTH+2];
   assign vaddr_diff    = 32'h0;
   assign paddr_diff    = 32'h0;
   assign data_diff     = 32'h0;
`endif

endmodule
